// File: rtl/outer_product_mac.sv
// ============================================================================
// outer_product_mac
// ----------------------------------------------------------------------------
// Consumes the three unload phases of a 3x3 operand memory bank and
// accumulates one outer product per phase into nine accumulators, giving
// C = W * X. The nine results are then streamed out in row-major order over
// a valid/ready handshake.
//
// Build option:
//   OUTER_PRODUCT_MAC_SIGNED_EN  defined   -> two's complement operands,
//                                             products sign-extended
//                                undefined -> unsigned operands, zero-extended
//
// Parameters:
//   DATA_W  operand width (bank word width)
//   ACC_W   accumulator / result width, must be >= 2*DATA_W+2
//
// Ports:
//   clk                       rising-edge clock
//   clear_n                   asynchronous active-low reset
//   start                     run request level; a run begins on its rising edge
//   unload1/2/3               registered phase selects to the memory bank
//   data_w1/2/3               W column k, rows 1..3 (combinational from bank)
//   data_x1/2/3               X row k, columns 1..3 (combinational from bank)
//   res_valid/res_ready       result handshake
//   res_data                  C[i][j]
//   res_idx                   i*3+j, 0..8
//   busy                      high in every state except IDLE
//   done                      one-cycle pulse after the last result is accepted
// ============================================================================

// ----------------------------------------------------------------------------
// mac_cell: one accumulator of the 3x3 array. Multiplies its row operand by
// its column operand and adds the extended product when enabled.
// ----------------------------------------------------------------------------
module mac_cell #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 10
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_w,
    input  logic [DATA_W-1:0] i_x,
    output logic [ACC_W-1:0]  o_acc
);

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    r_acc;

`ifdef OUTER_PRODUCT_MAC_SIGNED_EN
    // Operands widened to the full product width first so the multiply is
    // exact; the low 2*DATA_W bits hold the two's complement product.
    assign w_prod = $signed({{DATA_W{i_w[DATA_W-1]}}, i_w})
                  * $signed({{DATA_W{i_x[DATA_W-1]}}, i_x});
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
`else
    assign w_prod = {{DATA_W{1'b0}}, i_w} * {{DATA_W{1'b0}}, i_x};
    assign w_prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
`endif

    // Three terms always fit in ACC_W, so plain modular addition is exact.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// ----------------------------------------------------------------------------
// outer_product_mac: control FSM, 3x3 cell array, result streaming.
// ----------------------------------------------------------------------------
module outer_product_mac #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 10
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    output logic              unload1,
    output logic              unload2,
    output logic              unload3,
    input  logic [DATA_W-1:0] data_w1,
    input  logic [DATA_W-1:0] data_w2,
    input  logic [DATA_W-1:0] data_w3,
    input  logic [DATA_W-1:0] data_x1,
    input  logic [DATA_W-1:0] data_x2,
    input  logic [DATA_W-1:0] data_x3,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [3:0]        res_idx,
    output logic              busy,
    output logic              done
);

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;
    localparam int NUM_RES  = NUM_ROWS * NUM_COLS;
    localparam logic [3:0] LAST_IDX = 4'(NUM_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic       r_start_q;
    logic       w_start_rise;
    logic [2:0] r_unload;
    logic [2:0] w_unload_nxt;
    logic [3:0] r_idx;
    logic       w_accept;
    logic       w_acc_clr;
    logic       w_acc_en;

    logic [NUM_ROWS-1:0][DATA_W-1:0] w_wcol;
    logic [NUM_COLS-1:0][DATA_W-1:0] w_xrow;
    logic [NUM_RES-1:0][ACC_W-1:0]   w_acc;

    assign w_start_rise = start & ~r_start_q;
    assign w_accept     = (r_state == S_OUT) & res_ready;

    // Bank data are only meaningful while one unload line is high; the cells
    // sample them solely in the phase states.
    assign w_wcol = {data_w3, data_w2, data_w1};
    assign w_xrow = {data_x3, data_x2, data_x1};

    // ------------------------------------------------------------------
    // State register and registered companions
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_unload  <= 3'b000;
            r_idx     <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            // Unload lines are decoded from the next state so they are
            // clean flop outputs aligned exactly with each phase cycle.
            r_unload  <= w_unload_nxt;
            if (w_accept) begin
                r_idx <= (r_idx == LAST_IDX) ? 4'd0 : r_idx + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start_rise) w_state_nxt = S_PH1;
            S_PH1:  w_state_nxt = S_PH2;
            S_PH2:  w_state_nxt = S_PH3;
            S_PH3:  w_state_nxt = S_OUT;
            S_OUT:  if (w_accept && r_idx == LAST_IDX) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_unload_nxt = 3'b000;
        unique case (w_state_nxt)
            S_PH1:   w_unload_nxt = 3'b001;
            S_PH2:   w_unload_nxt = 3'b010;
            S_PH3:   w_unload_nxt = 3'b100;
            default: w_unload_nxt = 3'b000;
        endcase

        w_acc_clr = (r_state == S_IDLE) & w_start_rise;
        w_acc_en  = (r_state == S_PH1) | (r_state == S_PH2) | (r_state == S_PH3);

        res_valid = (r_state == S_OUT);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_FIN);
        res_idx   = res_valid ? r_idx : 4'd0;
        res_data  = res_valid ? w_acc[r_idx] : '0;
    end

    assign unload1 = r_unload[0];
    assign unload2 = r_unload[1];
    assign unload3 = r_unload[2];

    // ------------------------------------------------------------------
    // 3x3 cell array: cell (i,j) accumulates w_i * x_j, stored row-major
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
            mac_cell #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_cell (
                .clk     (clk),
                .clear_n (clear_n),
                .i_clr   (w_acc_clr),
                .i_en    (w_acc_en),
                .i_w     (w_wcol[gi]),
                .i_x     (w_xrow[gj]),
                .o_acc   (w_acc[gi*NUM_COLS+gj])
            );
        end
    end

endmodule
